// File: rtl/lfsr_capture_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_capture_ctrl_pkg
// Shared definitions for the LFSR capture controller and its button
// conditioner: FSM state encodings, wrap counter width, synchronizer depth
// and the saturating increment used by the wrap counter.
// -----------------------------------------------------------------------------
package lfsr_capture_ctrl_pkg;

  // FSM state encodings
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Completed-period counter width and its saturation value
  localparam int                WRAP_W   = 8;
  localparam logic [WRAP_W-1:0] WRAP_MAX = 8'hFF;

  // Number of flops in the button metastability synchronizer
  localparam int SYNC_DEPTH = 2;

  // Increment that sticks at WRAP_MAX instead of rolling over
  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    if (v == WRAP_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + WRAP_W'(1);
    end
  endfunction

endpackage

// File: rtl/lfsr_capture_ctrl_btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns a raw, bouncy, asynchronous push-button into a single-cycle press
// pulse: SYNC_DEPTH-flop synchronizer, then a debouncer that only accepts a
// level change after DEB_CYC consecutive cycles of disagreement, then a
// rising-edge detector. The pulse is registered together with the level
// update, so a clean rise reaches o_Press SYNC_DEPTH + DEB_CYC cycles later.
//
// Ports:
//   i_Clk   in   system clock
//   i_Rst   in   asynchronous active-low reset
//   i_Btn   in   raw push-button (asynchronous, active-high)
//   o_Press out  one-cycle pulse on each accepted press
// -----------------------------------------------------------------------------
module btn_conditioner
  import lfsr_capture_ctrl_pkg::*;
#(
  parameter int DEB_CYC = 500000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Btn,
  output logic o_Press
);

  localparam int               CNT_W    = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

  logic [SYNC_DEPTH-1:0] r_sync;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_level;
  logic                  r_press;
  logic                  w_sync_btn;
  logic                  w_mismatch;
  logic                  w_accept;

  assign w_sync_btn = r_sync[SYNC_DEPTH-1];
  assign w_mismatch = (w_sync_btn != r_level);
  // Last of DEB_CYC consecutive mismatching cycles: the new level is taken now
  assign w_accept   = w_mismatch && (r_cnt == CNT_LAST);
  assign o_Press    = r_press;

  // Metastability synchronizer for the asynchronous button input
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_DEPTH-2:0], i_Btn};
    end
  end

  // Debounce counter, debounced level and registered rising-edge pulse
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_accept && w_sync_btn;
      if (w_accept) begin
        r_level <= w_sync_btn;
        r_cnt   <= '0;
      end else if (w_mismatch) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        // Any agreeing cycle breaks the run and restarts the count
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/lfsr_capture_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_capture_ctrl
// Consumer/controller for a parameterised LFSR. Generates the LFSR enable
// strobe from a clock prescaler, freezes the LFSR and captures its value on a
// debounced button press, holds the capture for HOLD_TICKS tick periods,
// keeps a shift-register history of captures and counts completed LFSR
// periods from the LFSR done flag.
//
// Ports:
//   i_Clk          in   system clock
//   i_Rst          in   asynchronous active-low reset
//   i_Btn          in   raw push-button (asynchronous, active-high)
//   i_LFSR_Data    in   current LFSR value            [NUM_BITS]
//   i_LFSR_Done    in   LFSR "value equals seed" flag
//   o_LFSR_Enable  out  one-cycle enable strobe to the LFSR
//   o_Sample       out  last captured LFSR value      [NUM_BITS]
//   o_Sample_Valid out  one-cycle pulse when o_Sample updates
//   o_Holding      out  high while the capture is being held
//   o_History      out  past captures, newest in the low NUM_BITS
//   o_Wraps        out  saturating count of completed LFSR periods [8]
// -----------------------------------------------------------------------------
module lfsr_capture_ctrl
  import lfsr_capture_ctrl_pkg::*;
#(
  parameter int NUM_BITS   = 4,
  parameter int TICK_DIV   = 50000,
  parameter int DEB_CYC    = 500000,
  parameter int HOLD_TICKS = 100,
  parameter int HIST_DEPTH = 4
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic                           i_Btn,
  input  logic [NUM_BITS-1:0]            i_LFSR_Data,
  input  logic                           i_LFSR_Done,
  output logic                           o_LFSR_Enable,
  output logic [NUM_BITS-1:0]            o_Sample,
  output logic                           o_Sample_Valid,
  output logic                           o_Holding,
  output logic [HIST_DEPTH*NUM_BITS-1:0] o_History,
  output logic [WRAP_W-1:0]              o_Wraps
);

  localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam int                HOLD_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam int                HIST_W    = HIST_DEPTH * NUM_BITS;

  logic [TICK_W-1:0]   r_tick_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [0:0]          r_state;
  logic                r_enable;
  logic                r_en_d1;
  logic [NUM_BITS-1:0] r_sample;
  logic                r_valid;
  logic [HIST_W-1:0]   r_hist;
  logic [WRAP_W-1:0]   r_wraps;

  logic                w_press;
  logic                w_tick;
  logic                w_capture;
  logic [0:0]          w_state_nxt;
  logic [HIST_W-1:0]   w_hist_nxt;

  btn_conditioner #(
    .DEB_CYC (DEB_CYC)
  ) u_btn (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Btn   (i_Btn),
    .o_Press (w_press)
  );

  assign w_tick = (r_tick_cnt == TICK_LAST);
  // A single-entry history degenerates to just the new sample
  assign w_hist_nxt = (r_hist << NUM_BITS) | HIST_W'(i_LFSR_Data);

  assign o_LFSR_Enable  = r_enable;
  assign o_Sample       = r_sample;
  assign o_Sample_Valid = r_valid;
  assign o_Holding      = (r_state == ST_HOLD);
  assign o_History      = r_hist;
  assign o_Wraps        = r_wraps;

  // Free-running prescaler; HOLD only exits on a tick, which is also the wrap,
  // so the cadence after a hold always resumes from a fresh count
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TICK_W'(1);
    end
  end

  // Next-state and capture decision; presses are ignored while holding
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_press) begin
          w_state_nxt = ST_HOLD;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_HOLD: begin
        if (w_tick && (r_hold_cnt == HOLD_LAST)) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // FSM state, enable strobe and its one-cycle delay
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state  <= ST_RUN;
      r_enable <= 1'b0;
      r_en_d1  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      // A press in the same cycle as a tick wins: the LFSR is not advanced
      r_enable <= (r_state == ST_RUN) && w_tick && !w_press;
      r_en_d1  <= r_enable;
    end
  end

  // Capture register, history shift register and valid pulse
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_sample <= '0;
      r_hist   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_sample <= i_LFSR_Data;
        r_hist   <= w_hist_nxt;
      end
    end
  end

  // Tick periods spent in HOLD
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_hold_cnt <= '0;
    end else if (w_capture) begin
      r_hold_cnt <= '0;
    end else if ((r_state == ST_HOLD) && w_tick) begin
      r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
    end
  end

  // Completed periods: done only counts the cycle after a real LFSR step,
  // so a frozen LFSR sitting on its seed is not counted repeatedly
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_wraps <= '0;
    end else if (r_en_d1 && i_LFSR_Done) begin
      r_wraps <= sat_inc(r_wraps);
    end
  end

endmodule
